// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS core: opcodes, controller state
// encoding and datapath mux-select codes. The ALU control decoder reuses the
// opcode constants, so keep them in step with the ISA.
package mips_pkg;

  // Primary opcode field values
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // ALU-op codes that are not simply the instruction opcode
  localparam logic [5:0] ALUOP_ADD   = 6'h08;
  localparam logic [5:0] ALUOP_RTYPE = 6'h00;

  // Controller state encoding (also exported on o_state for debug)
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_REXEC  = 4'd3;
  localparam logic [3:0] S_RWB    = 4'd4;
  localparam logic [3:0] S_IEXEC  = 4'd5;
  localparam logic [3:0] S_IWB    = 4'd6;
  localparam logic [3:0] S_MEMADR = 4'd7;
  localparam logic [3:0] S_MEMRD  = 4'd8;
  localparam logic [3:0] S_MEMWB  = 4'd9;
  localparam logic [3:0] S_MEMWR  = 4'd10;
  localparam logic [3:0] S_BRANCH = 4'd11;
  localparam logic [3:0] S_JUMP   = 4'd12;
  localparam logic [3:0] S_TRAP   = 4'd13;

  // Datapath mux selects
  localparam logic       SRCA_PC      = 1'b0;
  localparam logic       SRCA_REG     = 1'b1;
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_BRANCH  = 2'b11;
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic       IORD_PC      = 1'b0;
  localparam logic       IORD_ALUOUT  = 1'b1;

  // Logical immediates are zero-extended, everything else sign-extended
  function automatic logic is_zero_ext(input logic [5:0] op);
    return (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
  endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Opcode classifier for the multi-cycle controller: picks the state that
// follows DECODE and flags zero-extended immediates.
// Build option: MC_CTRL_ILLEGAL_TRAP_EN sends unknown opcodes to TRAP
// instead of treating them as a NOP.
module mc_ctrl_decode
  import mips_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [3:0] next_state,
  output logic       zero_ext
);

  // Map the opcode to its execute-phase entry state
  always_comb begin
    zero_ext = is_zero_ext(opcode);
    case (opcode)
      OP_RTYPE:                          next_state = S_REXEC;
      OP_ADDI, OP_ADDIU, OP_ANDI,
      OP_ORI, OP_XORI, OP_LUI:           next_state = S_IEXEC;
      OP_LW, OP_SW:                      next_state = S_MEMADR;
      OP_BEQ, OP_BNE:                    next_state = S_BRANCH;
      OP_J:                              next_state = S_JUMP;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      default:                           next_state = S_TRAP;
`else
      default:                           next_state = S_FETCH;
`endif
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle main controller: a Moore FSM sequencing fetch, decode, execute,
// memory and write-back over a shared ALU / memory port. Outputs decode from
// the state register; only the FETCH IR/PC loads follow i_memReady directly.
// Build option: MC_CTRL_ILLEGAL_TRAP_EN adds the TRAP state and o_illegal.
module mc_control
  import mips_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [5:0] i_opcode,
  input  logic       i_memReady,
  output logic [5:0] o_aluOp,
  output logic       o_aluSrcA,
  output logic [1:0] o_aluSrcB,
  output logic       o_zeroExt,
  output logic [1:0] o_pcSrc,
  output logic       o_pcWrite,
  output logic       o_pcWriteCond,
  output logic       o_pcWriteCondNe,
  output logic       o_iorD,
  output logic       o_memRead,
  output logic       o_memWrite,
  output logic       o_irWrite,
  output logic       o_regDst,
  output logic       o_memToReg,
  output logic       o_regWrite,
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  output logic       o_illegal,
`endif
  output logic [3:0] o_state
);

  logic [3:0] state_reg;
  logic [3:0] state_next;
  logic [3:0] decode_next;
  logic       decode_zero_ext;

  mc_ctrl_decode u_decode (
    .opcode     (i_opcode),
    .next_state (decode_next),
    .zero_ext   (decode_zero_ext)
  );

  // State register; reset wins over any pending transition or memory wait
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  // Next-state logic; i_memReady only matters in the three memory states
  always_comb begin
    state_next = S_IDLE;
    case (state_reg)
      S_IDLE:   state_next = S_FETCH;
      S_FETCH:  state_next = i_memReady ? S_DECODE : S_FETCH;
      S_DECODE: state_next = decode_next;
      S_REXEC:  state_next = S_RWB;
      S_RWB:    state_next = S_FETCH;
      S_IEXEC:  state_next = S_IWB;
      S_IWB:    state_next = S_FETCH;
      S_MEMADR: state_next = (i_opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_next = i_memReady ? S_MEMWB : S_MEMRD;
      S_MEMWB:  state_next = S_FETCH;
      S_MEMWR:  state_next = i_memReady ? S_FETCH : S_MEMWR;
      S_BRANCH: state_next = S_FETCH;
      S_JUMP:   state_next = S_FETCH;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      S_TRAP:   state_next = S_TRAP;
`endif
      default:  state_next = S_IDLE;
    endcase
  end

  // Per-state control outputs; anything not named for a state stays 0
  always_comb begin
    o_aluOp         = 6'h00;
    o_aluSrcA       = SRCA_PC;
    o_aluSrcB       = SRCB_REG;
    o_zeroExt       = 1'b0;
    o_pcSrc         = PCSRC_ALU;
    o_pcWrite       = 1'b0;
    o_pcWriteCond   = 1'b0;
    o_pcWriteCondNe = 1'b0;
    o_iorD          = IORD_PC;
    o_memRead       = 1'b0;
    o_memWrite      = 1'b0;
    o_irWrite       = 1'b0;
    o_regDst        = 1'b0;
    o_memToReg      = 1'b0;
    o_regWrite      = 1'b0;
    case (state_reg)
      S_FETCH: begin
        o_memRead = 1'b1;
        o_aluSrcB = SRCB_FOUR;
        o_aluOp   = ALUOP_ADD;
        // IR load and PC+4 commit only when the fetch actually completes
        o_irWrite = i_memReady;
        o_pcWrite = i_memReady;
      end
      S_DECODE: begin
        // Branch target precomputed into ALUOut while the opcode is decoded
        o_aluSrcB = SRCB_BRANCH;
        o_aluOp   = ALUOP_ADD;
      end
      S_REXEC: begin
        o_aluSrcA = SRCA_REG;
        o_aluOp   = ALUOP_RTYPE;
      end
      S_RWB: begin
        o_aluOp    = ALUOP_RTYPE;
        o_regDst   = 1'b1;
        o_regWrite = 1'b1;
      end
      S_IEXEC: begin
        o_aluSrcA = SRCA_REG;
        o_aluSrcB = SRCB_IMM;
        o_aluOp   = i_opcode;
        o_zeroExt = decode_zero_ext;
      end
      S_IWB: o_regWrite = 1'b1;
      S_MEMADR: begin
        o_aluSrcA = SRCA_REG;
        o_aluSrcB = SRCB_IMM;
        o_aluOp   = i_opcode;
      end
      S_MEMRD: begin
        o_iorD    = IORD_ALUOUT;
        o_memRead = 1'b1;
      end
      S_MEMWB: begin
        o_memToReg = 1'b1;
        o_regWrite = 1'b1;
      end
      S_MEMWR: begin
        o_iorD     = IORD_ALUOUT;
        o_memWrite = 1'b1;
      end
      S_BRANCH: begin
        o_aluSrcA       = SRCA_REG;
        o_aluOp         = i_opcode;
        o_pcSrc         = PCSRC_ALUOUT;
        o_pcWriteCond   = (i_opcode == OP_BEQ);
        o_pcWriteCondNe = (i_opcode == OP_BNE);
      end
      S_JUMP: begin
        o_pcSrc   = PCSRC_JUMP;
        o_pcWrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign o_state = state_reg;

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  assign o_illegal = (state_reg == S_TRAP);
`endif

endmodule

// File: tb/tb_mc_control.sv
// Directed, table-driven bench for mc_control. Each table row gives the
// inputs applied in one cycle and the state/controls expected in that cycle.
module tb_mc_control;
  import mips_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       mem_ready;
  logic [5:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       zero_ext;
  logic [1:0] pc_src;
  logic       pc_write, pc_write_cond, pc_write_cond_ne;
  logic       iord, mem_read, mem_write, ir_write;
  logic       reg_dst, mem_to_reg, reg_write;
  logic [3:0] state;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic       illegal;
`endif

  mc_control dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_opcode        (opcode),
    .i_memReady      (mem_ready),
    .o_aluOp         (alu_op),
    .o_aluSrcA       (alu_src_a),
    .o_aluSrcB       (alu_src_b),
    .o_zeroExt       (zero_ext),
    .o_pcSrc         (pc_src),
    .o_pcWrite       (pc_write),
    .o_pcWriteCond   (pc_write_cond),
    .o_pcWriteCondNe (pc_write_cond_ne),
    .o_iorD          (iord),
    .o_memRead       (mem_read),
    .o_memWrite      (mem_write),
    .o_irWrite       (ir_write),
    .o_regDst        (reg_dst),
    .o_memToReg      (mem_to_reg),
    .o_regWrite      (reg_write),
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    .o_illegal       (illegal),
`endif
    .o_state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control word: {aluOp, srcA, srcB, zeroExt, pcSrc,
  //                {pcWrite, pcWriteCond, pcWriteCondNe},
  //                {iorD, memRead, memWrite, irWrite},
  //                {regDst, memToReg, regWrite}}
  localparam logic [21:0] C_ZERO      = 22'd0;
  localparam logic [21:0] C_FETCH_R   = {6'h08, 1'b0, 2'b01, 1'b0, 2'b00, 3'b100, 4'b0101, 3'b000};
  localparam logic [21:0] C_FETCH_W   = {6'h08, 1'b0, 2'b01, 1'b0, 2'b00, 3'b000, 4'b0100, 3'b000};
  localparam logic [21:0] C_DECODE    = {6'h08, 1'b0, 2'b11, 1'b0, 2'b00, 3'b000, 4'b0000, 3'b000};
  localparam logic [21:0] C_REXEC     = {6'h00, 1'b1, 2'b00, 1'b0, 2'b00, 3'b000, 4'b0000, 3'b000};
  localparam logic [21:0] C_RWB       = {6'h00, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 4'b0000, 3'b101};
  localparam logic [21:0] C_IEX_ORI   = {6'h0D, 1'b1, 2'b10, 1'b1, 2'b00, 3'b000, 4'b0000, 3'b000};
  localparam logic [21:0] C_IEX_ADDI  = {6'h08, 1'b1, 2'b10, 1'b0, 2'b00, 3'b000, 4'b0000, 3'b000};
  localparam logic [21:0] C_IWB       = {6'h00, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 4'b0000, 3'b001};
  localparam logic [21:0] C_MADR_LW   = {6'h23, 1'b1, 2'b10, 1'b0, 2'b00, 3'b000, 4'b0000, 3'b000};
  localparam logic [21:0] C_MADR_SW   = {6'h2B, 1'b1, 2'b10, 1'b0, 2'b00, 3'b000, 4'b0000, 3'b000};
  localparam logic [21:0] C_MEMRD     = {6'h00, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 4'b1100, 3'b000};
  localparam logic [21:0] C_MEMWB     = {6'h00, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 4'b0000, 3'b011};
  localparam logic [21:0] C_MEMWR     = {6'h00, 1'b0, 2'b00, 1'b0, 2'b00, 3'b000, 4'b1010, 3'b000};
  localparam logic [21:0] C_BR_BNE    = {6'h05, 1'b1, 2'b00, 1'b0, 2'b01, 3'b001, 4'b0000, 3'b000};
  localparam logic [21:0] C_BR_BEQ    = {6'h04, 1'b1, 2'b00, 1'b0, 2'b01, 3'b010, 4'b0000, 3'b000};
  localparam logic [21:0] C_JUMP      = {6'h00, 1'b0, 2'b00, 1'b0, 2'b10, 3'b100, 4'b0000, 3'b000};

  typedef struct {
    logic        rst_n;
    logic [5:0]  op;
    logic        rdy;
    logic [3:0]  st;
    logic [21:0] ctl;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic r, input logic [5:0] op, input logic rdy,
                              input logic [3:0] st, input logic [21:0] ctl);
    vec_t v;
    v.rst_n = r; v.op = op; v.rdy = rdy; v.st = st; v.ctl = ctl;
    return v;
  endfunction

  function automatic logic [21:0] dut_ctl();
    return {alu_op, alu_src_a, alu_src_b, zero_ext, pc_src,
            pc_write, pc_write_cond, pc_write_cond_ne,
            iord, mem_read, mem_write, ir_write,
            reg_dst, mem_to_reg, reg_write};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  // Drive one cycle's inputs at the falling edge, then let outputs settle
  task automatic step(input logic r, input logic [5:0] op, input logic rdy);
    @(negedge clk);
    rst_n = r; opcode = op; mem_ready = rdy;
    #1;
  endtask

  int n;

  initial begin
    rst_n = 1'b0; opcode = 6'h00; mem_ready = 1'b1;

    // Reset then R-type ADD
    vecs.push_back(mk(1'b0, 6'h00, 1'b1, S_IDLE,   C_ZERO));
    vecs.push_back(mk(1'b1, 6'h00, 1'b1, S_IDLE,   C_ZERO));
    vecs.push_back(mk(1'b1, 6'h00, 1'b1, S_FETCH,  C_FETCH_R));
    vecs.push_back(mk(1'b1, 6'h00, 1'b1, S_DECODE, C_DECODE));
    vecs.push_back(mk(1'b1, 6'h00, 1'b1, S_REXEC,  C_REXEC));
    vecs.push_back(mk(1'b1, 6'h00, 1'b1, S_RWB,    C_RWB));
    // LW with three wait cycles in MEMRD (8 cycles FETCH..MEMWB)
    vecs.push_back(mk(1'b1, 6'h23, 1'b1, S_FETCH,  C_FETCH_R));
    vecs.push_back(mk(1'b1, 6'h23, 1'b0, S_DECODE, C_DECODE));
    vecs.push_back(mk(1'b1, 6'h23, 1'b0, S_MEMADR, C_MADR_LW));
    vecs.push_back(mk(1'b1, 6'h23, 1'b0, S_MEMRD,  C_MEMRD));
    vecs.push_back(mk(1'b1, 6'h23, 1'b0, S_MEMRD,  C_MEMRD));
    vecs.push_back(mk(1'b1, 6'h23, 1'b0, S_MEMRD,  C_MEMRD));
    vecs.push_back(mk(1'b1, 6'h23, 1'b1, S_MEMRD,  C_MEMRD));
    vecs.push_back(mk(1'b1, 6'h23, 1'b0, S_MEMWB,  C_MEMWB));
    // BNE
    vecs.push_back(mk(1'b1, 6'h05, 1'b1, S_FETCH,  C_FETCH_R));
    vecs.push_back(mk(1'b1, 6'h05, 1'b1, S_DECODE, C_DECODE));
    vecs.push_back(mk(1'b1, 6'h05, 1'b0, S_BRANCH, C_BR_BNE));
    // ORI
    vecs.push_back(mk(1'b1, 6'h0D, 1'b1, S_FETCH,  C_FETCH_R));
    vecs.push_back(mk(1'b1, 6'h0D, 1'b1, S_DECODE, C_DECODE));
    vecs.push_back(mk(1'b1, 6'h0D, 1'b1, S_IEXEC,  C_IEX_ORI));
    vecs.push_back(mk(1'b1, 6'h0D, 1'b1, S_IWB,    C_IWB));
    // BEQ
    vecs.push_back(mk(1'b1, 6'h04, 1'b1, S_FETCH,  C_FETCH_R));
    vecs.push_back(mk(1'b1, 6'h04, 1'b1, S_DECODE, C_DECODE));
    vecs.push_back(mk(1'b1, 6'h04, 1'b1, S_BRANCH, C_BR_BEQ));
    // J
    vecs.push_back(mk(1'b1, 6'h02, 1'b1, S_FETCH,  C_FETCH_R));
    vecs.push_back(mk(1'b1, 6'h02, 1'b1, S_DECODE, C_DECODE));
    vecs.push_back(mk(1'b1, 6'h02, 1'b1, S_JUMP,   C_JUMP));
    // ADDI with a fetch wait; memReady low in DECODE is ignored
    vecs.push_back(mk(1'b1, 6'h08, 1'b0, S_FETCH,  C_FETCH_W));
    vecs.push_back(mk(1'b1, 6'h08, 1'b1, S_FETCH,  C_FETCH_R));
    vecs.push_back(mk(1'b1, 6'h08, 1'b0, S_DECODE, C_DECODE));
    vecs.push_back(mk(1'b1, 6'h08, 1'b0, S_IEXEC,  C_IEX_ADDI));
    vecs.push_back(mk(1'b1, 6'h08, 1'b0, S_IWB,    C_IWB));
    // SW aborted by reset mid-wait, then restart
    vecs.push_back(mk(1'b1, 6'h2B, 1'b1, S_FETCH,  C_FETCH_R));
    vecs.push_back(mk(1'b1, 6'h2B, 1'b1, S_DECODE, C_DECODE));
    vecs.push_back(mk(1'b1, 6'h2B, 1'b0, S_MEMADR, C_MADR_SW));
    vecs.push_back(mk(1'b1, 6'h2B, 1'b0, S_MEMWR,  C_MEMWR));
    vecs.push_back(mk(1'b0, 6'h2B, 1'b0, S_MEMWR,  C_MEMWR));
    vecs.push_back(mk(1'b1, 6'h2B, 1'b0, S_IDLE,   C_ZERO));
    vecs.push_back(mk(1'b1, 6'h2B, 1'b1, S_FETCH,  C_FETCH_R));
    vecs.push_back(mk(1'b1, 6'h2B, 1'b1, S_DECODE, C_DECODE));
    vecs.push_back(mk(1'b1, 6'h2B, 1'b1, S_MEMADR, C_MADR_SW));
    vecs.push_back(mk(1'b1, 6'h2B, 1'b1, S_MEMWR,  C_MEMWR));
    // Fetch of an unknown opcode; continued by the hand sequence below
    vecs.push_back(mk(1'b1, 6'h3F, 1'b1, S_FETCH,  C_FETCH_R));

    // Two reset edges so the table starts from a known state
    @(negedge clk);
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].op, vecs[i].rdy);
      check($sformatf("vec%0d_state", i), {28'd0, state}, {28'd0, vecs[i].st});
      check($sformatf("vec%0d_ctl", i), {10'd0, dut_ctl()}, {10'd0, vecs[i].ctl});
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
      check($sformatf("vec%0d_illegal", i), {31'd0, illegal}, 32'd0);
`endif
    end

    // Unknown opcode 6'h3F after DECODE
    step(1'b1, 6'h3F, 1'b1);
    check("illegal_decode_state", {28'd0, state}, {28'd0, S_DECODE});
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 6'h3F, k[0]);
      check($sformatf("trap_hold%0d_state", k), {28'd0, state}, {28'd0, S_TRAP});
      check($sformatf("trap_hold%0d_out", k), {9'd0, illegal, dut_ctl()}, {9'd0, 1'b1, C_ZERO});
    end
    step(1'b0, 6'h00, 1'b1);
    check("trap_before_reset_edge", {28'd0, state}, {28'd0, S_TRAP});
    step(1'b1, 6'h00, 1'b1);
    check("trap_cleared_by_reset", {9'd0, illegal, dut_ctl()}, {9'd0, 1'b0, C_ZERO});
`else
    step(1'b1, 6'h3F, 1'b1);
    check("illegal_nop_state", {28'd0, state}, {28'd0, S_FETCH});
    check("illegal_nop_ctl", {10'd0, dut_ctl()}, {10'd0, C_FETCH_R});
`endif

    // Reset latency: first FETCH exactly one cycle after release (bounded)
    step(1'b0, 6'h00, 1'b1);
    step(1'b1, 6'h00, 1'b1);
    check("release_state_idle", {28'd0, state}, {28'd0, S_IDLE});
    n = 0;
    do begin
      step(1'b1, 6'h00, 1'b1);
      n++;
    end while (state != S_FETCH && n < 20);
    check("first_fetch_latency", n, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
